rr_arb_16: RTL and testbench

RR_ARB_16 -- requirements
Module: rr_arb_16

---
 rtl/rr_arb_16.sv | 142 ++++++++++++++
 tb/tb_rr_arb_16.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_16.sv
// 16-way round-robin arbiter with registered grant/sel/valid outputs.
// Optional tenure limit compiled in by defining RR_ARB_TIMEOUT_EN.
module rr_arb_16 #(
    parameter int unsigned MAX_TENURE = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req,
    output logic [15:0] grant,
    output logic [3:0]  sel,
    output logic        valid
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  owner_q, owner_d;
    logic [3:0]  last_q, last_d;
    logic [15:0] grant_q, grant_d;
    logic        valid_q, valid_d;

    logic [3:0]  base;
    logic        hit;
    logic [3:0]  win;
    logic        rel;

    // Reject tenure limits outside the 1..255 range at elaboration.
    if (MAX_TENURE < 1 || MAX_TENURE > 255) begin : g_bad_tenure
        $error("rr_arb_16: MAX_TENURE must be 1..255");
    end

`ifdef RR_ARB_TIMEOUT_EN
    logic [7:0] tenure_q, tenure_d;
`endif

    // Round-robin search starting one past base, wrapping 15 -> 0.
    always_comb begin
        logic [3:0] idx;
        hit = 1'b0;
        win = 4'd0;
        idx = 4'd0;
        for (int k = 1; k <= 16; k++) begin
            idx = base + 4'(k);
            if (!hit && req[idx]) begin
                hit = 1'b1;
                win = idx;
            end
        end
    end

    // Next-state, owner bookkeeping and registered output values.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        base    = last_q;
        rel     = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
        tenure_d = tenure_q;
`endif
        if (state_q == BUSY) begin
            base = owner_q;
            rel  = !req[owner_q];
`ifdef RR_ARB_TIMEOUT_EN
            if (tenure_q >= 8'(MAX_TENURE)) begin
                rel = 1'b1;
            end
`endif
        end

        unique case (state_q)
            IDLE: begin
                if (hit) begin
                    state_d = BUSY;
                    owner_d = win;
`ifdef RR_ARB_TIMEOUT_EN
                    tenure_d = 8'd1;
`endif
                end
            end
            BUSY: begin
                if (rel) begin
                    last_d = owner_q;
                    if (hit) begin
                        owner_d = win;
`ifdef RR_ARB_TIMEOUT_EN
                        tenure_d = 8'd1;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
`ifdef RR_ARB_TIMEOUT_EN
                    tenure_d = tenure_q + 8'd1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == BUSY);
        grant_d = valid_d ? (16'd1 << owner_d) : 16'd0;
    end

    // State and output registers; reset clears everything at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 4'd0;
            last_q  <= 4'd15;
            grant_q <= 16'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    // Counts granted cycles of the current owner.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tenure_q <= 8'd0;
        end else begin
            tenure_q <= tenure_d;
        end
    end
`endif

    assign grant = grant_q;
    assign sel   = owner_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_rr_arb_16.sv
// Randomized and directed bench for rr_arb_16 against a
// behavioural round-robin model.
module tb_rr_arb_16;

    localparam int MAXT = 8;

    logic        clk;
    logic        reset;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  sel;
    logic        valid;

    int errs;
    int checks;

    // reference model state
    bit m_busy;
    int m_owner;
    int m_last;
    int m_ten;

    rr_arb_16 #(.MAX_TENURE(MAXT)) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .grant(grant),
        .sel  (sel),
        .valid(valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int pick(int from, logic [15:0] r);
        for (int k = 1; k <= 16; k++) begin
            if (r[(from + k) % 16]) return (from + k) % 16;
        end
        return -1;
    endfunction

    function automatic logic [20:0] exp_vec();
        logic [15:0] g;
        g = m_busy ? (16'd1 << m_owner) : 16'd0;
        return {g, 4'(m_owner), m_busy};
    endfunction

    task automatic model_reset();
        m_busy  = 0;
        m_owner = 0;
        m_last  = 15;
        m_ten   = 0;
    endtask

    task automatic model_edge(logic [15:0] r);
        int w;
        bit done;
        if (!m_busy) begin
            w = pick(m_last, r);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_ten = 1;
            end
        end else begin
            done = !r[m_owner];
`ifdef RR_ARB_TIMEOUT_EN
            if (m_ten >= MAXT) done = 1;
`endif
            if (done) begin
                m_last = m_owner;
                w = pick(m_last, r);
                if (w >= 0) begin
                    m_owner = w; m_ten = 1;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_ten++;
            end
        end
    endtask

    task automatic tick(logic [15:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
    endtask

    task automatic do_reset();
        req = 16'h0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({grant, sel, valid} !== 21'd0) begin
            errs++;
            $display("FAIL reset_state got g=%h s=%0d v=%b want 0",
                     grant, sel, valid);
        end
    endtask

    task automatic test_basic();
        do_reset();
        tick(16'h0001);
        checks++;
        if ({grant, sel, valid} !== {16'h0001, 4'd0, 1'b1}) begin
            errs++;
            $display("FAIL basic_grant got g=%h s=%0d v=%b want 0001/0/1",
                     grant, sel, valid);
        end
        tick(16'h0000);
        checks++;
        if ({grant, sel, valid} !== {16'h0000, 4'd0, 1'b0}) begin
            errs++;
            $display("FAIL basic_idle got g=%h s=%0d v=%b want 0000/0/0",
                     grant, sel, valid);
        end
    endtask

    task automatic test_alternate();
        int want[4] = '{0, 15, 0, 15};
        int got[$];
        int held;
        logic [15:0] r;
        do_reset();
        held = 0;
        for (int c = 0; c < 14; c++) begin
            r = 16'h8001;
            if (m_busy && held == 2) r[m_owner] = 1'b0;
            tick(r);
            held = (got.size() > 0 && got[$] == int'(sel)) ? held + 1 : 1;
            if (got.size() == 0 || got[$] != int'(sel)) got.push_back(sel);
            checks++;
            if ({grant, sel, valid} !== exp_vec()) begin
                errs++;
                $display("FAIL alt_model c=%0d got %h/%0d/%b want %h",
                         c, grant, sel, valid, exp_vec());
            end
            checks++;
            if (valid !== 1'b1) begin
                errs++;
                $display("FAIL alt_no_bubble c=%0d valid=%b want 1",
                         c, valid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= got.size() || got[i] != want[i]) begin
                errs++;
                $display("FAIL alt_seq i=%0d got %0d want %0d", i,
                         (i < got.size()) ? got[i] : -1, want[i]);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(16'h8000);
        tick(16'h8010);
        checks++;
        if ({grant, sel, valid} !== {16'h8000, 4'd15, 1'b1}) begin
            errs++;
            $display("FAIL wrap_hold got %h/%0d/%b want 8000/15/1",
                     grant, sel, valid);
        end
        tick(16'h0010);
        checks++;
        if ({grant, sel, valid} !== {16'h0010, 4'd4, 1'b1}) begin
            errs++;
            $display("FAIL wrap_next got %h/%0d/%b want 0010/4/1",
                     grant, sel, valid);
        end
    endtask

    task automatic test_sweep();
        logic [15:0] r;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            r = 16'hFFFF;
            if (m_busy) r[m_owner] = 1'b0;
            tick(r);
            checks++;
            if (sel !== 4'(i % 16) || valid !== 1'b1) begin
                errs++;
                $display("FAIL sweep i=%0d got s=%0d v=%b want %0d/1",
                         i, sel, valid, i % 16);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(16'h0020);
        tick(16'h0021);
        checks++;
        if ({grant, sel, valid} !== {16'h0020, 4'd5, 1'b1}) begin
            errs++;
            $display("FAIL mid_owner got %h/%0d/%b want 0020/5/1",
                     grant, sel, valid);
        end
        #3 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({grant, sel, valid} !== 21'd0) begin
            errs++;
            $display("FAIL mid_async got %h/%0d/%b want 0",
                     grant, sel, valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({grant, sel, valid} !== 21'd0) begin
            errs++;
            $display("FAIL mid_held got %h/%0d/%b want 0",
                     grant, sel, valid);
        end
        reset = 1'b0;
        tick(16'h0021);
        checks++;
        if ({grant, sel, valid} !== {16'h0001, 4'd0, 1'b1}) begin
            errs++;
            $display("FAIL mid_after got %h/%0d/%b want 0001/0/1",
                     grant, sel, valid);
        end
    endtask

    task automatic test_tenure();
        do_reset();
`ifdef RR_ARB_TIMEOUT_EN
        for (int c = 0; c < 48; c++) begin
            tick(16'h0003);
            checks++;
            if (sel !== 4'((c / MAXT) % 2) || valid !== 1'b1) begin
                errs++;
                $display("FAIL tenure_pair c=%0d got s=%0d v=%b want %0d",
                         c, sel, valid, (c / MAXT) % 2);
            end
        end
        for (int c = 0; c < 20; c++) begin
            tick(16'h0001);
            checks++;
            if ({grant, sel, valid} !== {16'h0001, 4'd0, 1'b1}) begin
                errs++;
                $display("FAIL tenure_solo c=%0d got %h/%0d/%b",
                         c, grant, sel, valid);
            end
        end
`else
        for (int c = 0; c < 30; c++) begin
            tick(16'h0003);
            checks++;
            if ({grant, sel, valid} !== {16'h0001, 4'd0, 1'b1}) begin
                errs++;
                $display("FAIL hold_forever c=%0d got %h/%0d/%b",
                         c, grant, sel, valid);
            end
        end
`endif
    endtask

    task automatic test_random();
        logic [15:0] r;
        int wait_cnt[16];
        do_reset();
        r = 16'h0;
        for (int i = 0; i < 16; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 9) < 3) begin
                r = 16'($urandom) & 16'($urandom);
            end else if (m_busy && $urandom_range(0, 9) < 4) begin
                r[m_owner] = 1'b0;
            end
            tick(r);
            checks++;
            if ({grant, sel, valid} !== exp_vec()) begin
                errs++;
                $display("FAIL rand_model c=%0d got %h/%0d/%b want %h",
                         c, grant, sel, valid, exp_vec());
            end
            checks++;
            if ($countones(grant) > 1 || grant[sel] !== valid) begin
                errs++;
                $display("FAIL rand_onehot c=%0d got g=%h s=%0d v=%b",
                         c, grant, sel, valid);
            end
        end
    endtask

    initial begin
        errs = 0;
        checks = 0;
        reset = 1'b1;
        req = 16'h0;
        model_reset();
        #1;
        test_reset();
        test_basic();
        test_alternate();
        test_wrap();
        test_sweep();
        test_reset_mid();
        test_tenure();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
